// File: rtl/cordic_iter_counter_if.sv
// cordic_iter_counter_if
//   Start/done handshake between a CORDIC controller and the iteration
//   sequencer.
//   start_i : one-cycle start request        (controller -> sequencer)
//   cont_i  : 0 = one-shot, 1 = continuous   (controller -> sequencer)
//   max_i   : terminal count M, 0 illegal    (controller -> sequencer)
//   busy_o  : high while counting            (sequencer -> controller)
//   done_o  : one-cycle completion pulse     (sequencer -> controller)
//   err_o   : one-cycle protocol-error pulse (sequencer -> controller)
//   master modport is the controller side, slave modport is the sequencer.
interface cordic_iter_counter_if #(
  parameter int unsigned Width = 16
);
  logic             start_i;
  logic             cont_i;
  logic [Width-1:0] max_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, cont_i, max_i,
    input  busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, cont_i, max_i,
    output busy_o, done_o, err_o
  );
endinterface

// File: rtl/cordic_iter_counter.sv
// cordic_iter_counter
//   Iteration sequencer for the CORDIC datapath. Counts 0..M-1 after an
//   accepted start, one-shot or continuous, with a combinational
//   terminal-count tick, stall enable, graceful stop of continuous runs and
//   protocol-error flagging.
//
//   Parameter Width (1..32): width of the count and terminal count.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_i   : asynchronous active-high reset
//     hs      : start/done handshake (slave side): start_i, cont_i, max_i,
//               busy_o, done_o, err_o
//     ena_i   : count enable, 0 stalls the count
//     stop_i  : continuous-mode stop request (level, sticky once seen in RUN)
//     abort_i : immediate abort, only when CORDIC_ITER_ABORT_EN is defined
//     cnt_o   : current iteration index (registered)
//     tick_o  : terminal-count strobe (combinational)
//
//   Build option: define CORDIC_ITER_ABORT_EN to add abort_i.
module cordic_iter_counter #(
  parameter int unsigned Width = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cordic_iter_counter_if.slave hs,
  input  logic              ena_i,
  input  logic              stop_i,
`ifdef CORDIC_ITER_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [Width-1:0]  cnt_o,
  output logic              tick_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] max_q, max_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic             busy_q, done_q, err_q, err_d;
  logic             start_ok;
  logic             at_last;

  assign start_ok = hs.start_i && (hs.max_i != '0);
  // max_q is never 0 in RUN, so max_q-1 cannot wrap there.
  assign at_last  = (cnt_q == (max_q - Width'(1)));
  assign tick_o   = (state_q == RUN) && ena_i && at_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_ok) begin
          max_d   = hs.max_i;
          cont_d  = hs.cont_i;
          stop_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (hs.start_i) begin
          err_d = 1'b1;
        end
      end

      RUN: begin
        if (hs.start_i) begin
          err_d = 1'b1;
        end
        if (stop_i) begin
          stop_d = 1'b1;
        end
        if (ena_i) begin
          if (at_last) begin
            cnt_d = '0;
            // stop_i is checked directly so a stop seen in the terminal
            // cycle itself still ends the run.
            if (!cont_q || stop_q || stop_i) begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + Width'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef CORDIC_ITER_ABORT_EN
    // Abort overrides terminal count and start; done_o is derived from
    // state_d, so sending state to IDLE also suppresses a pending done.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      err_q   <= err_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign hs.busy_o = busy_q;
  assign hs.done_o = done_q;
  assign hs.err_o  = err_q;

endmodule
